// File: rtl/sha256_pkg.sv
// Shared widths and default sizing for the SHA-256 core arbiter.
package sha256_pkg;
    localparam int SHA256_BLK_W         = 512;
    localparam int SHA256_DIG_W         = 256;
    localparam int SHA256_NREQ_DEF      = 4;
    localparam int SHA256_TAG_DEPTH_DEF = 128;
endpackage

// File: rtl/sha256_tag_fifo.sv
// Synchronous FIFO holding requester tags for blocks in flight in the core.
module sha256_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wr_data,
    input  logic                       pop,
    output logic [W-1:0]               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        // Pointers wrap naturally at the power-of-2 depth; the count never wraps.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/sha256_arbiter.sv
// Round-robin arbiter sharing one SHA-256 block core among NREQ requesters,
// tagging each issued block so in-order digests are routed back to their owner.
module sha256_arbiter
    import sha256_pkg::*;
#(
    parameter int NREQ      = SHA256_NREQ_DEF,
    parameter int TAG_DEPTH = SHA256_TAG_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*SHA256_BLK_W-1:0] req_msg,
    output logic [NREQ-1:0]              req_ready,
    output logic                         core_valid,
    output logic [SHA256_BLK_W-1:0]      core_msg,
    input  logic                         core_validout,
    input  logic [SHA256_DIG_W-1:0]      core_digest,
    output logic                         rsp_valid,
    output logic [$clog2(NREQ)-1:0]      rsp_id,
    output logic [SHA256_DIG_W-1:0]      rsp_digest,
    output logic                         busy,
    output logic                         err_underflow
);
    localparam int ID_W = $clog2(NREQ);
    localparam int CW   = $clog2(TAG_DEPTH) + 1;

    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic                    core_valid_q, core_valid_d;
    logic [SHA256_BLK_W-1:0] core_msg_q, core_msg_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]         rsp_id_q, rsp_id_d;
    logic [SHA256_DIG_W-1:0] rsp_digest_q, rsp_digest_d;
    logic                    err_underflow_q, err_underflow_d;

    logic                    grant_found;
    logic [ID_W-1:0]         grant_idx;
    logic                    accept;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [ID_W-1:0]         fifo_head;
    logic [CW-1:0]           fifo_count;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        accept    = !rst && grant_found && !fifo_full;
        if (accept) req_ready[grant_idx] = 1'b1;
        pop = core_validout && !fifo_empty;

        ptr_d = ptr_q;
        if (accept) ptr_d = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);

        core_valid_d = accept;
        core_msg_d   = accept ? req_msg[int'(grant_idx)*SHA256_BLK_W +: SHA256_BLK_W] : core_msg_q;

        rsp_valid_d     = pop;
        rsp_id_d        = pop ? fifo_head : rsp_id_q;
        rsp_digest_d    = pop ? core_digest : rsp_digest_q;
        err_underflow_d = err_underflow_q || (core_validout && fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q           <= '0;
            core_valid_q    <= 1'b0;
            core_msg_q      <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= '0;
            rsp_digest_q    <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            ptr_q           <= ptr_d;
            core_valid_q    <= core_valid_d;
            core_msg_q      <= core_msg_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_id_q        <= rsp_id_d;
            rsp_digest_q    <= rsp_digest_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    sha256_tag_fifo #(
        .W     (ID_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .wr_data (grant_idx),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign core_valid    = core_valid_q;
    assign core_msg      = core_msg_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_digest    = rsp_digest_q;
    assign err_underflow = err_underflow_q;
    assign busy          = (fifo_count != '0) || core_valid_q;
endmodule

// File: tb/tb_sha256_arbiter.sv
// Self-checking bench for sha256_arbiter: main instance at default depth plus a
// depth-4 instance for the tag-full behaviour.
module tb_sha256_arbiter;
    import sha256_pkg::*;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*512-1:0] req_msg = '0;
    logic [NREQ-1:0]     req_ready;
    logic                core_valid;
    logic [511:0]        core_msg;
    logic                core_validout = 1'b0;
    logic [255:0]        core_digest = '0;
    logic                rsp_valid;
    logic [ID_W-1:0]     rsp_id;
    logic [255:0]        rsp_digest;
    logic                busy;
    logic                err_underflow;

    logic [NREQ-1:0]     s_req_valid = '0;
    logic [NREQ*512-1:0] s_req_msg = '0;
    logic [NREQ-1:0]     s_req_ready;
    logic                s_core_valid;
    logic [511:0]        s_core_msg;
    logic                s_core_validout = 1'b0;
    logic [255:0]        s_core_digest = '0;
    logic                s_rsp_valid;
    logic [ID_W-1:0]     s_rsp_id;
    logic [255:0]        s_rsp_digest;
    logic                s_busy;
    logic                s_err_underflow;

    int n_vec = 0;
    int n_err = 0;
    logic [ID_W+255:0] exp_q[$];

    always #5 clk = ~clk;

    sha256_arbiter #(.NREQ(NREQ), .TAG_DEPTH(128)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_msg(req_msg),
        .req_ready(req_ready), .core_valid(core_valid), .core_msg(core_msg),
        .core_validout(core_validout), .core_digest(core_digest),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_digest(rsp_digest),
        .busy(busy), .err_underflow(err_underflow)
    );

    sha256_arbiter #(.NREQ(NREQ), .TAG_DEPTH(4)) dut_small (
        .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_msg(s_req_msg),
        .req_ready(s_req_ready), .core_valid(s_core_valid), .core_msg(s_core_msg),
        .core_validout(s_core_validout), .core_digest(s_core_digest),
        .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id), .rsp_digest(s_rsp_digest),
        .busy(s_busy), .err_underflow(s_err_underflow)
    );

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int j = 0; j < 16; j++) b[32*j +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [255:0] rand_dig();
        logic [255:0] d;
        for (int j = 0; j < 8; j++) d[32*j +: 32] = $urandom;
        return d;
    endfunction

    // Response scoreboard for the main instance.
    always @(negedge clk) begin
        logic [ID_W+255:0] e;
        if (!rst && rsp_valid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected: got id=%0d digest=%h, expected no response", rsp_id, rsp_digest);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_id, rsp_digest} !== e) begin
                    n_err++;
                    $display("FAIL rsp_data: got id=%0d digest=%h, expected id=%0d digest=%h",
                             rsp_id, rsp_digest, e[ID_W+255:256], e[255:0]);
                end
            end
        end
    end

    task automatic test_reset();
        rst         = 1'b1;
        req_valid   = 4'hf;
        s_req_valid = 4'hf;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (req_ready !== 4'h0 || s_req_ready !== 4'h0) begin
            n_err++;
            $display("FAIL ready_in_reset: got %b/%b, expected 0000/0000", req_ready, s_req_ready);
        end
        rst         = 1'b0;
        req_valid   = '0;
        s_req_valid = '0;
        @(negedge clk);
        n_vec++;
        if (core_valid !== 1'b0 || rsp_valid !== 1'b0 || err_underflow !== 1'b0 || busy !== 1'b0 ||
            core_msg !== '0 || rsp_id !== '0 || rsp_digest !== '0) begin
            n_err++;
            $display("FAIL reset_state: got cv=%b rv=%b err=%b busy=%b id=%0d, expected all zero",
                     core_valid, rsp_valid, err_underflow, busy, rsp_id);
        end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] exp_rdy;
        logic [255:0]    d;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) req_msg[i*512 +: 512] = rand_blk();
        req_valid = 4'hf;
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_rdy = 4'b0001 << (c % 4);
            n_vec++;
            if (req_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL rr_grant[%0d]: got %b, expected %b", c, req_ready, exp_rdy);
            end
            @(negedge clk);
            n_vec++;
            if (core_valid !== 1'b1 || core_msg !== req_msg[(c % 4)*512 +: 512]) begin
                n_err++;
                $display("FAIL rr_core[%0d]: got valid=%b msg=%h, expected valid=1 msg of req %0d",
                         c, core_valid, core_msg[63:0], c % 4);
            end
        end
        req_valid = '0;
        @(negedge clk);
        n_vec++;
        if (core_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rr_idle: got core_valid=%b busy=%b, expected 0/1", core_valid, busy);
        end
        for (int c = 0; c < 8; c++) begin
            d             = rand_dig();
            core_validout = 1'b1;
            core_digest   = d;
            exp_q.push_back({ID_W'(c % 4), d});
            @(negedge clk);
        end
        core_validout = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rr_drain: got busy=%b pending=%0d, expected 0/0", busy, exp_q.size());
        end
    endtask

    task automatic test_single();
        logic [511:0] m;
        logic [255:0] d;
        m = {8{64'h3433_3231_6162_636f}};
        @(negedge clk);
        req_msg[2*512 +: 512] = m;
        req_valid = 4'b0100;
        #1;
        n_vec++;
        if (req_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL single_ready: got %b, expected 0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        n_vec++;
        if (core_valid !== 1'b1 || core_msg !== m || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_core: got valid=%b busy=%b msg=%h", core_valid, busy, core_msg[63:0]);
        end
        @(negedge clk);
        n_vec++;
        if (core_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_wait: got core_valid=%b busy=%b, expected 0/1", core_valid, busy);
        end
        d             = rand_dig();
        core_validout = 1'b1;
        core_digest   = d;
        exp_q.push_back({2'd2, d});
        @(negedge clk);
        core_validout = 1'b0;
        n_vec++;
        if (rsp_valid !== 1'b1 || err_underflow !== 1'b0) begin
            n_err++;
            $display("FAIL single_rsp: got rsp_valid=%b err=%b, expected 1/0", rsp_valid, err_underflow);
        end
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_done: got rsp_valid=%b busy=%b, expected 0/0", rsp_valid, busy);
        end
    endtask

    task automatic test_ordering();
        int           ord [3];
        logic [255:0] d;
        ord[0] = 3; ord[1] = 1; ord[2] = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_msg[ord[k]*512 +: 512] = rand_blk();
            req_valid = 4'b0001 << ord[k];
            #1;
            n_vec++;
            if (req_ready !== (4'b0001 << ord[k])) begin
                n_err++;
                $display("FAIL order_grant[%0d]: got %b, expected req %0d", k, req_ready, ord[k]);
            end
        end
        @(negedge clk);
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            d             = rand_dig();
            core_validout = 1'b1;
            core_digest   = d;
            exp_q.push_back({ID_W'(ord[k]), d});
            @(negedge clk);
            core_validout = 1'b0;
            @(negedge clk);
        end
        n_vec++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL order_drain: got pending=%0d busy=%b, expected 0/0", exp_q.size(), busy);
        end
    endtask

    task automatic test_underflow_reset();
        @(negedge clk);
        core_validout = 1'b1;
        core_digest   = rand_dig();
        @(negedge clk);
        core_validout = 1'b0;
        n_vec++;
        if (err_underflow !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL underflow: got err=%b rsp_valid=%b, expected 1/0", err_underflow, rsp_valid);
        end
        req_valid = 4'b0111;
        repeat (3) @(negedge clk);
        req_valid = '0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL inflight_busy: got busy=%b, expected 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || err_underflow !== 1'b0 || core_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: got busy=%b err=%b cv=%b, expected 0/0/0", busy, err_underflow, core_valid);
        end
        req_valid = 4'hf;
        #1;
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL mid_reset_ptr: got %b, expected 0001", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
        core_validout = 1'b1;
        core_digest   = rand_dig();
        @(negedge clk);
        core_validout = 1'b0;
        n_vec++;
        if (err_underflow !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stale_digest: got err=%b rsp_valid=%b, expected 1/0", err_underflow, rsp_valid);
        end
    endtask

    task automatic test_full();
        logic [255:0] d;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) s_req_msg[i*512 +: 512] = rand_blk();
        s_req_valid = 4'hf;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_vec++;
            if (s_req_ready !== (4'b0001 << c)) begin
                n_err++;
                $display("FAIL full_fill[%0d]: got %b, expected req %0d", c, s_req_ready, c);
            end
            @(negedge clk);
        end
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++;
            if (s_req_ready !== 4'b0000 || s_busy !== 1'b1) begin
                n_err++;
                $display("FAIL full_block[%0d]: got ready=%b busy=%b, expected 0000/1", c, s_req_ready, s_busy);
            end
            @(negedge clk);
        end
        d               = rand_dig();
        s_core_validout = 1'b1;
        s_core_digest   = d;
        #1;
        n_vec++;
        if (s_req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL full_pop_cycle: got %b, expected 0000", s_req_ready);
        end
        @(negedge clk);
        s_core_validout = 1'b0;
        #1;
        n_vec++;
        if (s_req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL full_regrant: got %b, expected 0001", s_req_ready);
        end
        n_vec++;
        if (s_rsp_valid !== 1'b1 || s_rsp_id !== 2'd0 || s_rsp_digest !== d || s_err_underflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_rsp: got rv=%b id=%0d err=%b, expected 1/0/0", s_rsp_valid, s_rsp_id, s_err_underflow);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (s_req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL full_again: got %b, expected 0000", s_req_ready);
        end
        s_req_valid = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_ordering();
        test_underflow_reset();
        test_full();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL final_queue: got %0d pending responses, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
